// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the MISO transmitter and the MOSI receiver.
package spi_pkg;

    localparam int                        SPI_DATA_WIDTH = 8;
    localparam logic [SPI_DATA_WIDTH-1:0] SPI_FILL_BYTE  = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, followed by an edge-detect
// register that yields single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI Mode 0 slave transmitter: drives MISO MSB first from a one-entry holding
// register, with pins oversampled in the clk domain.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = DATA_WIDTH'(SPI_FILL_BYTE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  byte_done,
    output logic                  underrun,
    output logic                  aborted
);

    localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pin  (cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_reload;
    logic                  r_miso;
    logic                  r_miso_oe;
    logic                  r_byte_done;
    logic                  r_underrun;
    logic                  r_aborted;

    spi_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] w_hold_nxt;
    logic                  w_hold_valid_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         w_bit_cnt_nxt;
    logic                  w_reload_nxt;
    logic                  w_miso_nxt;
    logic                  w_miso_oe_nxt;
    logic                  w_byte_done_nxt;
    logic                  w_underrun_nxt;
    logic                  w_aborted_nxt;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_word;
    logic                  w_accept;

    assign w_accept    = tx_valid && !r_hold_valid;
    assign w_load_word = r_hold_valid ? r_hold : FILL_BYTE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_reload     <= 1'b0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_byte_done  <= 1'b0;
            r_underrun   <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_reload     <= w_reload_nxt;
            r_miso       <= w_miso_nxt;
            r_miso_oe    <= w_miso_oe_nxt;
            r_byte_done  <= w_byte_done_nxt;
            r_underrun   <= w_underrun_nxt;
            r_aborted    <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_reload_nxt     = r_reload;
        w_miso_nxt       = r_miso;
        w_miso_oe_nxt    = r_miso_oe;
        w_byte_done_nxt  = 1'b0;
        w_underrun_nxt   = 1'b0;
        w_aborted_nxt    = 1'b0;
        w_load           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_nxt = '0;
                w_miso_oe_nxt = 1'b0;
                w_reload_nxt  = 1'b0;
                if (w_cs_fall) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Deselect takes priority over any sclk edge in the same cycle.
                if (w_cs_rise) begin
                    w_state_nxt   = ST_IDLE;
                    w_miso_oe_nxt = 1'b0;
                    w_miso_nxt    = 1'b0;
                    w_bit_cnt_nxt = '0;
                    w_reload_nxt  = 1'b0;
                    w_aborted_nxt = (r_bit_cnt != '0);
                end else if (w_sclk_rise) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt   = '0;
                        w_byte_done_nxt = 1'b1;
                        w_reload_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    if (r_reload) begin
                        w_load       = 1'b1;
                        w_reload_nxt = 1'b0;
                    end else begin
                        w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
                        w_miso_nxt  = r_shift[DATA_WIDTH-2];
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Hold is only consumed here; accept cannot coincide since ready is low while full.
        if (w_load) begin
            w_shift_nxt   = w_load_word;
            w_miso_nxt    = w_load_word[DATA_WIDTH-1];
            w_miso_oe_nxt = 1'b1;
            if (r_hold_valid) begin
                w_hold_valid_nxt = 1'b0;
            end else begin
                w_underrun_nxt = 1'b1;
            end
        end

        if (w_accept) begin
            w_hold_nxt       = tx_data;
            w_hold_valid_nxt = 1'b1;
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_miso_oe;
    assign tx_ready  = !r_hold_valid;
    assign byte_done = r_byte_done;
    assign underrun  = r_underrun;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a Mode 0 master model with a word-level reference of
// what the master must receive and which status pulses must appear.
module tb_spi_slave_tx;

    localparam logic [7:0] FILL = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       byte_done;
    logic       underrun;
    logic       aborted;

    always #5 clk = ~clk;

    spi_slave_tx #(.DATA_WIDTH(8), .FILL_BYTE(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .byte_done (byte_done),
        .underrun  (underrun),
        .aborted   (aborted)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: held word, word on the wire, bit position within it.
    bit         m_hv;
    logic [7:0] m_hold;
    logic [7:0] m_cur;
    int         m_idx;
    bit         m_pend;
    bit         m_sel;
    int         exp_bd, exp_ur, exp_ab;
    int         act_bd, act_ur, act_ab;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    int         hp = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void fetch();
        if (m_hv) begin
            m_cur = m_hold;
            m_hv  = 1'b0;
        end else begin
            m_cur = FILL;
            exp_ur++;
        end
    endfunction

    task automatic cs_low();
        cs_n   = 1'b0;
        m_sel  = 1'b1;
        m_idx  = 0;
        m_pend = 1'b0;
        fetch();
        wait_cyc(5);
        chk("tx_ready_after_load", tx_ready, !m_hv);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        if (m_sel && m_idx != 0) exp_ab++;
        m_sel  = 1'b0;
        m_pend = 1'b0;
        wait_cyc(5);
    endtask

    task automatic sclk_rise();
        sclk = 1'b1;
        if (m_sel) begin
            chk("miso_bit", miso, m_cur[7 - m_idx]);
            rx_byte = {rx_byte[6:0], miso};
            m_idx++;
            if (m_idx == 8) begin
                m_idx  = 0;
                m_pend = 1'b1;
                exp_bd++;
                rx_q.push_back(rx_byte);
            end
        end
        wait_cyc(hp);
    endtask

    task automatic sclk_fall();
        sclk = 1'b0;
        if (m_sel && m_pend) begin
            fetch();
            m_pend = 1'b0;
        end
        wait_cyc(hp);
    endtask

    task automatic push(input logic [7:0] d, input int nblk);
        if (!m_hv) begin
            tx_data  = d;
            tx_valid = 1'b1;
            wait_cyc(1);
            tx_valid = 1'b0;
            m_hold   = d;
            m_hv     = 1'b1;
            chk("tx_ready_after_push", tx_ready, !m_hv);
        end else begin
            repeat (nblk) begin
                tx_data  = d;
                tx_valid = 1'b1;
                chk("tx_ready_blocked", tx_ready, !m_hv);
                wait_cyc(1);
            end
            tx_valid = 1'b0;
        end
    endtask

    task automatic xfer_word(input int nb, input bit pm, input logic [7:0] pd, input bit csf_last);
        for (int i = 0; i < nb; i++) begin
            sclk_rise();
            if (pm && i == 2) push(pd, 2);
            if (i == nb - 1 && csf_last) begin
                cs_high();
                sclk = 1'b0;
                wait_cyc(hp);
            end else begin
                sclk_fall();
            end
        end
    endtask

    task automatic check_counts();
        chk("byte_done_count", act_bd, exp_bd);
        chk("underrun_count", act_ur, exp_ur);
        chk("aborted_count", act_ab, exp_ab);
        chk("tx_ready_idle", tx_ready, !m_hv);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        tx_valid = 1'b0;
        m_hv     = 1'b0;
        m_sel    = 1'b0;
        m_idx    = 0;
        m_pend   = 1'b0;
        wait_cyc(3);
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_byte_done", byte_done, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        rst_n = 1'b1;
        wait_cyc(3);
    endtask

    // Per-cycle checks: miso_oe follows cs_n three clocks late; pulses last one cycle.
    logic h0 = 1'b1, h1 = 1'b1, h2 = 1'b1;
    logic p_bd = 1'b0, p_ur = 1'b0, p_ab = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
        end else begin
            h2 = h1; h1 = h0; h0 = cs_n;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("miso_oe_track", miso_oe, !h2);
            if (byte_done) begin act_bd++; chk("byte_done_width", p_bd, 1'b0); end
            if (underrun)  begin act_ur++; chk("underrun_width",  p_ur, 1'b0); end
            if (aborted)   begin act_ab++; chk("aborted_width",   p_ab, 1'b0); end
            p_bd = byte_done;
            p_ur = underrun;
            p_ab = aborted;
        end else begin
            p_bd = 1'b0; p_ur = 1'b0; p_ab = 1'b0;
        end
    end

    initial begin
        int bd0, ur0, ab0;
        tx_data = 8'h00;
        exp_bd = 0; exp_ur = 0; exp_ab = 0;
        act_bd = 0; act_ur = 0; act_ab = 0;
        rx_byte = 8'h00;
        do_reset();

        // A5 in one frame, deselect while sclk is still high
        bd0 = exp_bd;
        push(8'hA5, 1);
        chk("tx_ready_loaded", tx_ready, 1'b0);
        rx_q.delete();
        cs_low();
        chk("tx_ready_freed", tx_ready, 1'b1);
        xfer_word(8, 1'b0, 8'h00, 1'b1);
        chk("a5_byte", rx_q[0], 8'hA5);
        chk("a5_byte_done_delta", act_bd - bd0, 1);
        check_counts();

        // 3C then C3 back to back, C3 supplied during the first word
        bd0 = act_bd; ur0 = act_ur;
        push(8'h3C, 1);
        rx_q.delete();
        cs_low();
        xfer_word(8, 1'b1, 8'hC3, 1'b0);
        xfer_word(8, 1'b0, 8'h00, 1'b1);
        chk("b2b_first", rx_q[0], 8'h3C);
        chk("b2b_second", rx_q[1], 8'hC3);
        chk("b2b_byte_done_delta", act_bd - bd0, 2);
        chk("b2b_underrun_delta", act_ur - ur0, 0);
        check_counts();

        // Empty hold: fill byte and one underrun pulse at selection
        ur0 = act_ur;
        rx_q.delete();
        cs_low();
        chk("fill_underrun_delta", act_ur - ur0, 1);
        xfer_word(8, 1'b0, 8'h00, 1'b1);
        chk("fill_byte", rx_q[0], 8'h00);
        check_counts();

        // Abort after 3 bits of FF; next frame must not resume FF
        ab0 = act_ab;
        push(8'hFF, 1);
        cs_low();
        xfer_word(3, 1'b0, 8'h00, 1'b0);
        cs_high();
        chk("abort_delta", act_ab - ab0, 1);
        chk("abort_oe_low", miso_oe, 1'b0);
        rx_q.delete();
        cs_low();
        xfer_word(8, 1'b0, 8'h00, 1'b1);
        chk("after_abort_byte", rx_q[0], 8'h00);
        check_counts();

        // Reset in the middle of a word, then a fresh frame from bit 7
        push(8'h5A, 1);
        cs_low();
        xfer_word(4, 1'b0, 8'h00, 1'b0);
        do_reset();
        push(8'h96, 1);
        rx_q.delete();
        cs_low();
        xfer_word(8, 1'b0, 8'h00, 1'b1);
        chk("post_reset_byte", rx_q[0], 8'h96);
        check_counts();

        // sclk activity while deselected, and tx_valid held against a full hold
        bd0 = act_bd; ur0 = act_ur; ab0 = act_ab;
        push(8'h81, 1);
        repeat (4) begin
            sclk_rise();
            sclk_fall();
        end
        push(8'h7E, 3);
        chk("desel_byte_done", act_bd - bd0, 0);
        chk("desel_underrun", act_ur - ur0, 0);
        chk("desel_aborted", act_ab - ab0, 0);
        rx_q.delete();
        cs_low();
        xfer_word(8, 1'b0, 8'h00, 1'b1);
        chk("held_byte_kept", rx_q[0], 8'h81);
        check_counts();

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int  nw, part;
            bit  csf;
            hp = $urandom_range(4, 6);
            if ($urandom_range(0, 1) == 1) push(8'($urandom), 1);
            cs_low();
            nw   = $urandom_range(1, 3);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            csf  = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++) begin
                xfer_word((w == nw - 1) ? part : 8, 1'($urandom_range(0, 1)),
                          8'($urandom), (w == nw - 1) && csf);
            end
            if (!csf) cs_high();
            check_counts();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
